// File: rtl/simd_inst_fetch_pkg.sv
// Shared configuration for the SIMD instruction fetch/issue block.
// Holds the TauCfg sizing constants and the NOP opcode encoding.
package simd_inst_fetch_pkg;
    localparam int N_INST           = 16;
    localparam int INST_W           = 32;
    localparam int WORK_BW          = 16;
    localparam int VDIM             = 4;
    localparam int MAX_WARP         = 4;
    localparam int MAX_PENDING_INST = 4;
    localparam logic [5:0] OPCODE_NOP = 6'd0;
endpackage

// File: rtl/simd_commit_fifo.sv
// In-order pending-instruction FIFO with writeback credit counter and commit engine.
// Emits one registered commit pulse per instruction; NOP entries need no writeback credit.
module simd_commit_fifo
    import simd_inst_fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_BW  = 5,
    parameter int WID_BW = 2,
    parameter int CNT_BW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [PC_BW-1:0]  push_pc,
    input  logic [WID_BW-1:0] push_warpid,
    input  logic              push_nop,
    input  logic              wb_dval,
    output logic              commit_dval,
    output logic [PC_BW-1:0]  commit_pc,
    output logic [WID_BW-1:0] commit_warpid,
    output logic              empty,
    output logic              err
);
    localparam int PTR_BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_BW = $clog2(DEPTH + 1);

    logic [PC_BW-1:0]  pc_q  [DEPTH];
    logic [WID_BW-1:0] wid_q [DEPTH];
    logic [DEPTH-1:0]  nop_q;
    logic [PTR_BW-1:0] wr_ptr, rd_ptr;
    logic [OCC_BW-1:0] occ;
    logic [CNT_BW-1:0] wbc;

    logic full, head_nop, pop, push_ok, wb_dec, wb_ovf;

    function automatic logic [PTR_BW-1:0] inc_ptr(input logic [PTR_BW-1:0] p);
        return (p == PTR_BW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (occ == OCC_BW'(DEPTH));
    assign empty    = (occ == '0);
    assign head_nop = nop_q[rd_ptr];
    // A writeback arriving this cycle can retire the head directly.
    assign pop      = !empty && (head_nop || (wbc != '0) || wb_dval);
    assign push_ok  = push && !full;
    assign wb_dec   = pop && !head_nop;
    assign wb_ovf   = wb_dval && !wb_dec && (wbc == CNT_BW'(DEPTH));
    assign err      = (push && full) || wb_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            wbc           <= '0;
            nop_q         <= '0;
            commit_dval   <= 1'b0;
            commit_pc     <= '0;
            commit_warpid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                wid_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                pc_q[wr_ptr]  <= push_pc;
                wid_q[wr_ptr] <= push_warpid;
                nop_q[wr_ptr] <= push_nop;
                wr_ptr        <= inc_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= inc_ptr(rd_ptr);
            if (push_ok && !pop)
                occ <= occ + 1'b1;
            else if (!push_ok && pop)
                occ <= occ - 1'b1;

            if (wb_dval && !wb_dec) begin
                if (!wb_ovf)
                    wbc <= wbc + 1'b1;
            end else if (!wb_dval && wb_dec) begin
                wbc <= wbc - 1'b1;
            end

            commit_dval <= pop;
            if (pop) begin
                commit_pc     <= pc_q[rd_ptr];
                commit_warpid <= wid_q[rd_ptr];
            end
        end
    end
endmodule

// File: rtl/simd_inst_fetch.sv
// SIMD instruction fetch/decode/issue: F (memory read) -> D (decode, ALU issue) -> in-order commit.
// Optional SIMD_FETCH_PERF_EN adds issue and stall performance counters.
module simd_inst_fetch
    import simd_inst_fetch_pkg::*;
#(
    parameter int N_INST    = simd_inst_fetch_pkg::N_INST,
    parameter int INST_W    = simd_inst_fetch_pkg::INST_W,
    parameter int WBW       = WORK_BW,
    parameter int VDIM      = simd_inst_fetch_pkg::VDIM,
    parameter int MAX_WARP  = simd_inst_fetch_pkg::MAX_WARP,
    parameter int N_PENDING = MAX_PENDING_INST,
    localparam int INST_BW  = $clog2(N_INST + 1),
    localparam int WID_BW   = (MAX_WARP > 1) ? $clog2(MAX_WARP) : 1,
    localparam int CNT_BW   = $clog2(N_PENDING + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cfg_we,
    input  logic [INST_BW-1:0]        i_cfg_addr,
    input  logic [INST_W-1:0]         i_cfg_data,
    input  logic                      inst_rdy,
    output logic                      inst_ack,
    input  logic [INST_BW-1:0]        i_pc,
    input  logic [WID_BW-1:0]         i_warpid,
    input  logic [VDIM-1:0][WBW-1:0]  i_bofs,
    input  logic [VDIM-1:0][WBW-1:0]  i_aofs,
    output logic                      alu_rdy,
    input  logic                      alu_ack,
    output logic [INST_W-1:0]         o_inst,
    output logic [5:0]                o_opcode,
    output logic [INST_BW-1:0]        o_pc,
    output logic [WID_BW-1:0]         o_warpid,
    output logic [VDIM-1:0][WBW-1:0]  o_bofs,
    output logic [VDIM-1:0][WBW-1:0]  o_aofs,
    input  logic                      i_wb_dval,
    output logic                      inst_commit_dval,
    output logic [INST_BW-1:0]        o_commit_pc,
    output logic [WID_BW-1:0]         o_commit_warpid,
    output logic                      o_err
`ifdef SIMD_FETCH_PERF_EN
    ,
    output logic [31:0]               o_perf_issue,
    output logic [31:0]               o_perf_stall
`endif
);
    localparam int AW = $clog2(N_INST);

    logic [INST_W-1:0] mem [N_INST];

    logic                     f_v, d_v;
    logic [INST_W-1:0]        f_inst, d_inst;
    logic [INST_BW-1:0]       f_pc, d_pc;
    logic [WID_BW-1:0]        f_warpid, d_warpid;
    logic [VDIM-1:0][WBW-1:0] f_bofs, f_aofs, d_bofs, d_aofs;

    logic f_adv, d_done, d_nop, cfg_ok, fifo_empty, fifo_err;

    assign d_nop    = (d_inst[INST_W-1 -: 6] == OPCODE_NOP);
    assign alu_rdy  = d_v && !d_nop;
    assign d_done   = (alu_rdy && alu_ack) || (d_v && d_nop);
    assign f_adv    = f_v && (!d_v || d_done);
    assign inst_ack = inst_rdy && (!f_v || f_adv);
    // Memory may only change while nothing fetched from it is still in flight.
    assign cfg_ok   = !f_v && !d_v && fifo_empty;

    always_ff @(posedge i_clk) begin
        if (i_cfg_we && cfg_ok && (i_cfg_addr < INST_BW'(N_INST)))
            mem[i_cfg_addr[AW-1:0]] <= i_cfg_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            f_v      <= 1'b0;
            f_inst   <= '0;
            f_pc     <= '0;
            f_warpid <= '0;
            f_bofs   <= '0;
            f_aofs   <= '0;
            d_v      <= 1'b0;
            d_inst   <= '0;
            d_pc     <= '0;
            d_warpid <= '0;
            d_bofs   <= '0;
            d_aofs   <= '0;
        end else begin
            if (inst_ack) begin
                f_v      <= 1'b1;
                f_inst   <= (i_pc < INST_BW'(N_INST)) ? mem[i_pc[AW-1:0]] : '0;
                f_pc     <= i_pc;
                f_warpid <= i_warpid;
                f_bofs   <= i_bofs;
                f_aofs   <= i_aofs;
            end else if (f_adv) begin
                f_v <= 1'b0;
            end

            if (f_adv) begin
                d_v      <= 1'b1;
                d_inst   <= f_inst;
                d_pc     <= f_pc;
                d_warpid <= f_warpid;
                d_bofs   <= f_bofs;
                d_aofs   <= f_aofs;
            end else if (d_done) begin
                d_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_err <= 1'b0;
        else if ((i_cfg_we && !cfg_ok) || fifo_err)
            o_err <= 1'b1;
    end

    assign o_inst   = d_inst;
    assign o_opcode = d_inst[INST_W-1 -: 6];
    assign o_pc     = d_pc;
    assign o_warpid = d_warpid;
    assign o_bofs   = d_bofs;
    assign o_aofs   = d_aofs;

    simd_commit_fifo #(
        .DEPTH  (N_PENDING),
        .PC_BW  (INST_BW),
        .WID_BW (WID_BW),
        .CNT_BW (CNT_BW)
    ) u_commit (
        .clk           (i_clk),
        .rst           (i_rst),
        .push          (d_done),
        .push_pc       (d_pc),
        .push_warpid   (d_warpid),
        .push_nop      (d_nop),
        .wb_dval       (i_wb_dval),
        .commit_dval   (inst_commit_dval),
        .commit_pc     (o_commit_pc),
        .commit_warpid (o_commit_warpid),
        .empty         (fifo_empty),
        .err           (fifo_err)
    );

`ifdef SIMD_FETCH_PERF_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_perf_issue <= '0;
            o_perf_stall <= '0;
        end else begin
            if (alu_rdy && alu_ack)
                o_perf_issue <= o_perf_issue + 32'd1;
            if (alu_rdy && !alu_ack)
                o_perf_stall <= o_perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: doc/simd_inst_fetch.md
Name: simd_inst_fetch

Overview:
- Consumer of the SIMD driver's instruction-issue stream: accepts {pc, warpid, bofs, aofs} per instruction, reads the instruction word from a local instruction memory, decodes the opcode and issues to the ALU pipeline.
- Tracks issued instructions in order and returns the one-pulse-per-instruction commit (inst_commit dval) that feeds the driver's pending-instruction semaphore.
- NOP instructions bypass the ALU and commit internally, still in order.

Parameters:
N_INST, 16, instruction memory depth
INST_W, 32, instruction word width
WBW, 16, offset width (TauCfg::WORK_BW)
VDIM, 4, vector dimensions
MAX_WARP, 4, warp count
N_PENDING, 4, max in-flight instructions (TauCfg::MAX_PENDING_INST)
Derived: INST_BW=$clog2(N_INST+1), WID_BW=$clog2(MAX_WARP), CNT_BW=$clog2(N_PENDING+1)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_cfg_we  in  1  instruction memory write strobe
i_cfg_addr  in  INST_BW  write address
i_cfg_data  in  INST_W  write data
inst_rdy  in  1  upstream instruction valid
inst_ack  out  1  upstream accept
i_pc  in  INST_BW  instruction index
i_warpid  in  WID_BW  warp id
i_bofs  in  WBW x VDIM  block offsets
i_aofs  in  WBW x VDIM  accumulation offsets
alu_rdy  out  1  instruction to ALU valid
alu_ack  in  1  ALU accept
o_inst  out  INST_W  raw instruction word
o_opcode  out  6  decoded opcode, inst[31:26]
o_pc  out  INST_BW  pc of issued instruction
o_warpid  out  WID_BW  warp id
o_bofs  out  WBW x VDIM  block offsets
o_aofs  out  WBW x VDIM  accumulation offsets
i_wb_dval  in  1  ALU writeback done, one pulse per non-NOP instruction, in order
inst_commit_dval  out  1  commit pulse to driver semaphore
o_commit_pc  out  INST_BW  pc of committed instruction
o_commit_warpid  out  WID_BW  warp of committed instruction
o_err  out  1  sticky protocol error

Behaviour:
- Reset: all valid flags 0, alu_rdy=0, inst_commit_dval=0, o_err=0, FIFO pointers/counts 0, data regs 0. Instruction memory contents are not reset.
- Handshake: a transfer occurs when rdy&&ack in the same cycle. The rdy side holds rdy and data stable until ack.
- Stage F (fetch), valid f_v:
  - inst_ack = inst_rdy && (!f_v || f_adv).
  - On ack, register pc/warpid/bofs/aofs and perform the synchronous memory read at i_pc. The read data register updates only on ack, so it holds under stall.
- Stage D (decode/output), valid d_v:
  - f_adv = f_v && (!d_v || d_done), where d_done = (alu_rdy&&alu_ack) || (d_v && d_nop).
  - d_nop = opcode==0.
  - alu_rdy = d_v && !d_nop.
  - A NOP leaves D in one cycle without alu_rdy.
- Latency: inst_ack to alu_rdy is 2 cycles. Full throughput is one instruction per cycle with alu_ack held high.
- Pending FIFO, depth N_PENDING, entries {pc, warpid, nop}:
  - Push on d_done.
  - Push when full sets o_err and the entry is dropped. The driver's semaphore guarantees this never happens in legal operation.
- Writeback credit counter wbc (CNT_BW bits):
  - +1 on i_wb_dval.
  - -1 on commit of a non-NOP entry.
  - Increment and decrement in the same cycle leave it unchanged.
  - Increment at max sets o_err.
- Commit engine, at most one commit per cycle, FIFO non-empty:
  - If the head is a NOP: commit.
  - Else if wbc>0, or i_wb_dval this cycle: commit.
  - Commit pops the head and registers inst_commit_dval=1 with o_commit_pc/warpid on the next cycle (1-cycle pulse).
  - A wb arriving with an empty FIFO is counted into wbc, not an error. The ALU cannot return before issue because the push happens on the issue cycle.
- Push and pop in the same cycle are allowed. On an empty FIFO, push has no bypass: commit happens at earliest the cycle after push.
- Config write:
  - Accepted only when f_v=d_v=0 and the FIFO is empty.
  - Otherwise the write is dropped and o_err is set.
  - A write and a read of the same address in one cycle return the old data.
- Asynchronous reset mid-operation discards all in-flight state immediately. The driver's semaphore must be reset together with this block.

Optional Feature:
SIMD_FETCH_PERF_EN
- Defined: adds outputs o_perf_issue[31:0] and o_perf_stall[31:0], both reset to 0.
  - o_perf_issue: +1 per ALU handshake.
  - o_perf_stall: +1 per cycle with alu_rdy && !alu_ack.
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- TauCfg package: N_INST, WORK_BW, VDIM, MAX_WARP, MAX_PENDING_INST, and new OPCODE_NOP=6'd0 and INST_W.
- Sub-module simd_commit_fifo: pending FIFO + wb credit counter + commit engine, with push/wb inputs and commit/err outputs.

Test Plan:
- Load mem[3]=32'h0400_0000 (opcode 1). Send pc=3, warp=2 with alu_ack=1 -> alu_rdy 2 cycles after inst_ack, o_opcode=1, o_warpid=2. Pulse i_wb_dval -> inst_commit_dval next cycle with o_commit_pc=3.
- Back-to-back pcs 0..7, all non-NOP, alu_ack=1, wb returned 3 cycles later each -> 1 issue/cycle, 8 commits in pc order, o_err=0.
- alu_ack held 0 for 5 cycles with 3 queued instructions -> inst_ack drops after F and D fill, outputs stable, no loss or duplication after release.
- Sequence pc {A non-NOP, B NOP, C non-NOP}: B commits only after A's wb, C after its own wb. Commit order A,B,C. No alu_rdy for B.
- Push N_PENDING+1 instructions without wb -> o_err=1 sticky until reset. Async reset mid-stream -> all outputs 0 immediately.
- i_cfg_we while d_v=1 -> memory unchanged (read back old word), o_err=1. With SIMD_FETCH_PERF_EN, 4 stall cycles -> o_perf_stall=4.
